// File: rtl/ai_player.sv
// ai_player: automated Connect-4 opponent.
// On trigger (sw && player && !term) it snapshots the board and column heights,
// scans one candidate column per cycle in preference order 3,2,4,1,5,0,6,
// then registers the chosen drop position and holds a level move request.
// Ports:
//   clk            system clock (rising edge)
//   rst            asynchronous active-low reset
//   grid[97:0]     board image; [97:84] selection row (ignored),
//                  cell (c,r) at [13-2c+14r -: 2], 00 empty / 01 p0 / 10 p1
//   column_counts  height of column c at [3c+2 -: 3]
//   player         side to move, 1 = AI
//   sw             AI enable
//   term           game over, overrides everything
//   ai[6:0]        MSB bit index of chosen cell, 13-2c+14h
//   move           level-held drop request
//   busy           high in SCAN, DECIDE and MOVE
module ai_player (
  input  logic        clk,
  input  logic        rst,
  input  logic [97:0] grid,
  input  logic [20:0] column_counts,
  input  logic        player,
  input  logic        sw,
  input  logic        term,
  output logic [6:0]  ai,
  output logic        move,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, MOVE, HOLD} state_t;

  state_t      state, state_nxt;
  logic        trig;
  logic [83:0] snap_grid;
  logic [20:0] snap_counts;
  logic [2:0]  k;
  logic        win_vld, blk_vld, leg_vld;
  logic [2:0]  win_col, blk_col, leg_col;

  logic [2:0]  cand_col, cand_h;
  logic [4:0]  cand_hidx;
  logic        cand_legal, cand_win, cand_blk;
  logic [2:0]  sel_col, sel_h;
  logic [4:0]  sel_hidx;
  logic [6:0]  ai_nxt;

  // The selection row is not part of the playing field.
  logic unused_sel_row;
  assign unused_sel_row = ^grid[97:84];

  assign trig = sw & player & ~term;

  function automatic logic [2:0] pref_col(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd3;
      3'd1:    return 3'd2;
      3'd2:    return 3'd4;
      3'd3:    return 3'd1;
      3'd4:    return 3'd5;
      3'd5:    return 3'd0;
      default: return 3'd6;
    endcase
  endfunction

  // Off-board cells return 11, which matches neither player code.
  function automatic logic [1:0] cell_at(input logic [83:0] g, input int c, input int r);
    logic [6:0] idx;
    if (c < 0 || c > 6 || r < 0 || r > 5) return 2'b11;
    idx = 7'(13 - 2 * c + 14 * r);
    return g[idx -: 2];
  endfunction

  function automatic int run_len(input logic [83:0] g, input int c, input int r,
                                 input int dc, input int dr, input logic [1:0] code);
    int   n;
    logic go;
    n  = 0;
    go = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      if (go && cell_at(g, c + int'(i) * dc, r + int'(i) * dr) == code) n++;
      else go = 1'b0;
    end
    return n;
  endfunction

  function automatic logic connects(input logic [83:0] g, input int c, input int h,
                                    input logic [1:0] code);
    return (run_len(g, c, h, -1,  0, code) + run_len(g, c, h, 1,  0, code) >= 3) ||
           (run_len(g, c, h,  0, -1, code) >= 3) ||
           (run_len(g, c, h, -1, -1, code) + run_len(g, c, h, 1,  1, code) >= 3) ||
           (run_len(g, c, h, -1,  1, code) + run_len(g, c, h, 1, -1, code) >= 3);
  endfunction

  // One candidate column evaluated per scan step, from the snapshot only.
  always_comb begin
    cand_col   = pref_col(k);
    cand_hidx  = 5'(3 * cand_col);
    cand_h     = snap_counts[cand_hidx +: 3];
    cand_legal = (cand_h < 3'd6);
    cand_win   = cand_legal && connects(snap_grid, int'(cand_col), int'(cand_h), 2'b10);
    cand_blk   = cand_legal && connects(snap_grid, int'(cand_col), int'(cand_h), 2'b01);
  end

  always_comb begin
    sel_col = leg_col;
    if (win_vld)      sel_col = win_col;
    else if (blk_vld) sel_col = blk_col;
    sel_hidx = 5'(3 * sel_col);
    sel_h    = snap_counts[sel_hidx +: 3];
    ai_nxt   = 7'd13 - {3'b000, sel_col, 1'b0} + 7'(14 * sel_h);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; term wins over every other input via trig or explicitly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = SCAN;
      SCAN:    if (!trig) state_nxt = IDLE;
               else if (k == 3'd6) state_nxt = DECIDE;
      DECIDE:  if (term) state_nxt = IDLE;
               else if (leg_vld) state_nxt = MOVE;
               else state_nxt = HOLD;
      MOVE:    if (!player || !sw || term) state_nxt = IDLE;
      HOLD:    if (!trig) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    move = 1'b0;
    busy = 1'b0;
    case (state)
      SCAN, DECIDE: busy = 1'b1;
      MOVE: begin
        busy = 1'b1;
        move = 1'b1;
      end
      default: ;
    endcase
  end

  // Snapshot, scan bookkeeping and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_grid   <= '0;
      snap_counts <= '0;
      k           <= '0;
      win_vld     <= 1'b0;
      blk_vld     <= 1'b0;
      leg_vld     <= 1'b0;
      win_col     <= '0;
      blk_col     <= '0;
      leg_col     <= '0;
      ai          <= '0;
    end else begin
      case (state)
        IDLE: if (trig) begin
          snap_grid   <= grid[83:0];
          snap_counts <= column_counts;
          k           <= '0;
          win_vld     <= 1'b0;
          blk_vld     <= 1'b0;
          leg_vld     <= 1'b0;
          win_col     <= '0;
          blk_col     <= '0;
          leg_col     <= '0;
        end
        SCAN: if (trig) begin
          k <= k + 3'd1;
          if (cand_legal && !leg_vld) begin
            leg_vld <= 1'b1;
            leg_col <= cand_col;
          end
          if (cand_win && !win_vld) begin
            win_vld <= 1'b1;
            win_col <= cand_col;
          end
          if (cand_blk && !blk_vld) begin
            blk_vld <= 1'b1;
            blk_col <= cand_col;
          end
        end
        DECIDE: if (!term && leg_vld) ai <= ai_nxt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ai_player.sv
module tb_ai_player;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [97:0] grid;
  logic [20:0] column_counts;
  logic        player, sw, term;
  logic [6:0]  ai;
  logic        move, busy;

  always #5 clk = ~clk;

  ai_player dut (
    .clk(clk), .rst(rst), .grid(grid), .column_counts(column_counts),
    .player(player), .sw(sw), .term(term), .ai(ai), .move(move), .busy(busy)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic       chk_en   = 1'b0;
  logic       exp_move = 1'b0;
  logic       exp_busy = 1'b0;
  logic [6:0] exp_ai   = '0;

  int bd[7][6];
  int ht[7];

  task automatic check(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Compare process: outputs checked mid-cycle against the expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(exp_busy));
      check("move", int'(move), int'(exp_move));
      if (exp_move) check("ai", int'(ai), int'(exp_ai));
    end
  end

  // ---------------- board model ----------------
  function automatic int cell_of(input int c, input int r);
    if (c < 0 || c > 6 || r < 0 || r > 5) return -1;
    return bd[c][r];
  endfunction

  // A move at (c,h) connects if some 4-long window through it is all 'code'
  // (vertical: only the window ending at the new piece).
  function automatic bit connects(input int c, input int h, input int code);
    int dcs[3] = '{1, 1, 1};
    int drs[3] = '{0, 1, -1};
    for (int d = 0; d < 3; d++) begin
      for (int s = -3; s <= 0; s++) begin
        bit ok = 1'b1;
        for (int j = 0; j < 4; j++) begin
          int p = s + j;
          if (p != 0 && cell_of(c + p * dcs[d], h + p * drs[d]) != code) ok = 1'b0;
        end
        if (ok) return 1'b1;
      end
    end
    return cell_of(c, h - 1) == code && cell_of(c, h - 2) == code &&
           cell_of(c, h - 3) == code;
  endfunction

  function automatic int model_ai();
    int ord[7] = '{3, 2, 4, 1, 5, 0, 6};
    int win = -1, blk = -1, leg = -1;
    for (int i = 0; i < 7; i++) begin
      int c = ord[i];
      int h = ht[c];
      if (h < 6) begin
        int pos = 13 - 2 * c + 14 * h;
        if (leg < 0) leg = pos;
        if (win < 0 && connects(c, h, 2)) win = pos;
        if (blk < 0 && connects(c, h, 1)) blk = pos;
      end
    end
    if (win >= 0) return win;
    if (blk >= 0) return blk;
    return leg;
  endfunction

  task automatic clear_board();
    for (int c = 0; c < 7; c++) begin
      ht[c] = 0;
      for (int r = 0; r < 6; r++) bd[c][r] = 0;
    end
  endtask

  task automatic pack();
    grid = '0;
    grid[97:84] = 14'h2AAA;
    column_counts = '0;
    for (int c = 0; c < 7; c++) begin
      column_counts[3 * c + 2 -: 3] = 3'(ht[c]);
      for (int r = 0; r < 6; r++) grid[13 - 2 * c + 14 * r -: 2] = 2'(bd[c][r]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Trigger a scan from IDLE and follow it through T8; want < 0 means no legal column.
  task automatic run_scan(input int want, input bit scramble);
    sw = 1'b1; player = 1'b1; term = 1'b0;
    tick();
    exp_busy = 1'b1; exp_move = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (scramble && i == 2) begin
        grid = '0;
        column_counts = '0;
      end
    end
    tick();
    if (want >= 0) begin
      exp_move = 1'b1;
      exp_ai   = 7'(want);
    end else begin
      exp_busy = 1'b0;
    end
  endtask

  // Consumer drops player two cycles after move rises.
  task automatic finish_move();
    tick();
    tick();
    player = 1'b0;
    tick();
    exp_move = 1'b0; exp_busy = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int mdl;
    grid = '0; column_counts = '0; player = 1'b0; sw = 1'b0; term = 1'b0;
    #3;
    check("reset_ai", int'(ai), 0);
    check("reset_move", int'(move), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    tick(); tick();

    // Empty board
    clear_board(); pack();
    mdl = model_ai();
    check("model_empty", mdl, 7);
    run_scan(mdl, 1'b0);
    finish_move();

    // Win: p1 on (2,0),(3,0),(4,0); column 1 preferred over 5
    clear_board();
    bd[2][0] = 2; bd[3][0] = 2; bd[4][0] = 2;
    bd[0][0] = 1; bd[0][1] = 1; bd[6][0] = 1;
    ht[0] = 2; ht[2] = 1; ht[3] = 1; ht[4] = 1; ht[6] = 1;
    pack();
    mdl = model_ai();
    check("model_win", mdl, 11);
    run_scan(mdl, 1'b0);
    finish_move();

    // Block column 0; inputs wiped mid-scan must not matter
    clear_board();
    bd[0][0] = 1; bd[0][1] = 1; bd[0][2] = 1; bd[3][0] = 2; bd[6][0] = 2;
    ht[0] = 3; ht[3] = 1; ht[6] = 1;
    pack();
    mdl = model_ai();
    check("model_block", mdl, 55);
    run_scan(mdl, 1'b1);
    finish_move();

    // Columns 3 and 2 full, no threats: first legal is column 4 at h=2
    clear_board();
    for (int r = 0; r < 6; r++) begin
      bd[3][r] = (r % 2 == 0) ? 1 : 2;
      bd[2][r] = (r % 2 == 0) ? 2 : 1;
    end
    bd[4][0] = 1; bd[4][1] = 2;
    ht[2] = 6; ht[3] = 6; ht[4] = 2;
    pack();
    mdl = model_ai();
    check("model_full34", mdl, 33);
    run_scan(mdl, 1'b0);
    finish_move();

    // All columns full: HOLD with no move until sw drops, then a fresh scan works
    clear_board();
    for (int c = 0; c < 7; c++) ht[c] = 6;
    pack();
    mdl = model_ai();
    check("model_allfull", mdl, -1);
    run_scan(mdl, 1'b0);
    tick(); tick(); tick();
    sw = 1'b0;
    tick();
    clear_board(); pack();
    run_scan(7, 1'b0);
    finish_move();

    // Abort: sw drops at scan step 3
    clear_board(); pack();
    sw = 1'b1; player = 1'b1;
    tick();
    exp_busy = 1'b1;
    tick(); tick(); tick();
    sw = 1'b0;
    tick();
    exp_busy = 1'b0;
    tick(); tick(); tick(); tick();
    player = 1'b0;

    // term at trigger: nothing starts
    term = 1'b1; sw = 1'b1; player = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    player = 1'b0; term = 1'b0;
    tick();

    // Reset during MOVE drops outputs without a clock edge
    clear_board(); pack();
    run_scan(7, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("rst_move", int'(move), 0);
    check("rst_ai", int'(ai), 0);
    check("rst_busy", int'(busy), 0);
    exp_move = 1'b0; exp_busy = 1'b0;
    player = 1'b0; sw = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
